// File: rtl/lorenz_pkg.sv
// Shared fixed-point definitions for consumers of the Lorenz solver stream.
package lorenz_pkg;

  localparam int Q_INT  = 7;
  localparam int Q_FRAC = 25;

  typedef logic signed [31:0] q7_25_t;

  typedef struct packed {
    logic   sat;
    q7_25_t value;
  } q_conv_t;

  // Round half up to Q7.(out_w-7) and clamp positive overflow; the result is
  // sign-extended in value, so callers keep only the low out_w bits.
  function automatic q_conv_t q7_25_to_q(input q7_25_t din, input int out_w);
    q_conv_t            res;
    logic signed [32:0] wide;
    logic signed [32:0] max_v;
    int                 f;
    f    = Q_FRAC - (out_w - Q_INT);
    wide = {din[31], din};
    if (f > 0) wide = wide + (33'sd1 <<< (f - 1));
    wide      = wide >>> f;
    max_v     = (33'sd1 <<< (out_w - 1)) - 33'sd1;
    res.sat   = (wide > max_v);
    res.value = res.sat ? max_v[31:0] : wide[31:0];
    return res;
  endfunction

endpackage

// File: rtl/lorenz_stream_decimator_if.sv
// Three-coordinate stream bundle; W is the per-coordinate width.
interface lorenz_stream_decimator_if #(
  parameter int W = 32
);
  // A beat transfers on a rising clk edge where valid && ready are both high;
  // once valid is raised, the data holds until that edge.
  logic         valid;
  logic         ready;
  logic [W-1:0] data_x;
  logic [W-1:0] data_y;
  logic [W-1:0] data_z;

  modport master (output valid, data_x, data_y, data_z, input ready);
  modport slave  (input valid, data_x, data_y, data_z, output ready);
endinterface

// File: rtl/lorenz_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy output and synchronous clear.
module lorenz_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full && !clear;
  assign rd_en = pop && !empty && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Head reads as zero when empty so nothing stale is ever presented.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lorenz_stream_decimator.sv
// Keeps every decim-th solver triple, narrows it to Q7.(OUT_W-7) and queues it for the sink.
module lorenz_stream_decimator
  import lorenz_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int OUT_W   = 16,
  parameter int DECIM_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DECIM_W-1:0]         decim,
  input  logic                       flush,
  lorenz_stream_decimator_if.slave   s_axis,
  lorenz_stream_decimator_if.master  m_axis,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = 3 * OUT_W;

  function automatic logic [OUT_W:0] convert(input q7_25_t din);
    q_conv_t r;
    r = q7_25_to_q(din, OUT_W);
    return {r.sat, r.value[OUT_W-1:0]};
  endfunction

  logic [DECIM_W-1:0] cnt;
  logic [DECIM_W-1:0] eff_m1;
  logic               ready_q;
  logic               in_fire;
  logic               push;
  logic               pop;
  logic               empty;
  logic [OUT_W:0]     cx;
  logic [OUT_W:0]     cy;
  logic [OUT_W:0]     cz;
  logic [FW-1:0]      fifo_dout;
  logic [LW-1:0]      level_next;

  assign eff_m1  = (decim == '0) ? '0 : decim - DECIM_W'(1);
  assign in_fire = s_axis.valid && ready_q;
  assign push    = in_fire && (cnt == '0) && !flush;
  assign pop     = m_axis.valid && m_axis.ready && !flush;

  assign cx = convert(s_axis.data_x);
  assign cy = convert(s_axis.data_y);
  assign cz = convert(s_axis.data_z);

  // Ready is registered from the post-edge occupancy, so it drops on the
  // edge that fills the FIFO and rises on the edge that frees a slot.
  always_comb begin
    level_next = level;
    if (push && !pop)      level_next = level + LW'(1);
    else if (!push && pop) level_next = level - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      ready_q  <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (in_fire) cnt <= (cnt >= eff_m1) ? '0 : cnt + DECIM_W'(1);
      if (push && (cx[OUT_W] || cy[OUT_W] || cz[OUT_W])) sat_flag <= 1'b1;
      ready_q <= (level_next != LW'(DEPTH));
    end
  end

  lorenz_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .din     ({cx[OUT_W-1:0], cy[OUT_W-1:0], cz[OUT_W-1:0]}),
    .pop     (pop),
    .dout    (fifo_dout),
    .level   (level),
    .empty   (empty)
  );

  assign s_axis.ready  = ready_q;
  assign m_axis.valid  = !empty;
  assign m_axis.data_x = fifo_dout[FW-1 -: OUT_W];
  assign m_axis.data_y = fifo_dout[2*OUT_W-1 -: OUT_W];
  assign m_axis.data_z = fifo_dout[OUT_W-1:0];

endmodule

// File: tb/tb_lorenz_stream_decimator.sv
// Bench for lorenz_stream_decimator: vector table, hand-written corner sequences, random traffic vs a model.
module tb_lorenz_stream_decimator;

  localparam int DEPTH   = 16;
  localparam int OUT_W   = 16;
  localparam int DECIM_W = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic               clk     = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush   = 1'b0;
  logic [DECIM_W-1:0] decim   = 16'd1;
  logic [LW-1:0]      level;
  logic               sat_flag;

  always #5 clk = ~clk;

  lorenz_stream_decimator_if #(.W(32))    s_if ();
  lorenz_stream_decimator_if #(.W(OUT_W)) m_if ();

  lorenz_stream_decimator #(
    .DEPTH   (DEPTH),
    .OUT_W   (OUT_W),
    .DECIM_W (DECIM_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .decim    (decim),
    .flush    (flush),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .level    (level),
    .sat_flag (sat_flag)
  );

  // ---------------- scoreboard ----------------
  int                     total = 0;
  int                     bad   = 0;
  logic [3*OUT_W-1:0]     exp_q[$];
  int                     in_idx  = 0;
  logic                   exp_sat = 1'b0;
  int                     eff;
  logic [OUT_W:0]         mx, my, mz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: value/2^16 rounded half up (floor of v+0.5 LSB), clamped to 0x7FFF.
  function automatic logic [OUT_W:0] model_conv(input logic [31:0] v);
    longint r;
    r = (longint'($signed(v)) + 64'sd32768) >>> 16;
    if (r > 64'sd32767) return {1'b1, 16'h7fff};
    return {1'b0, r[15:0]};
  endfunction

  // Every accepted sample k (counted from reset/flush) is kept when k mod eff == 0.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      in_idx  = 0;
      exp_sat = 1'b0;
    end else begin
      check("level", 64'(level), 64'(exp_q.size()));
      check("m_valid", 64'(m_if.valid), 64'(exp_q.size() != 0));
      check("sat_flag", 64'(sat_flag), 64'(exp_sat));
      if (m_if.valid && exp_q.size() != 0)
        check("m_data", 64'({m_if.data_x, m_if.data_y, m_if.data_z}), 64'(exp_q[0]));
      if (flush) begin
        exp_q.delete();
        in_idx  = 0;
        exp_sat = 1'b0;
      end else begin
        if (m_if.valid && m_if.ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (s_if.valid && s_if.ready) begin
          eff = (decim == 0) ? 1 : int'(decim);
          if (in_idx % eff == 0) begin
            mx = model_conv(s_if.data_x);
            my = model_conv(s_if.data_y);
            mz = model_conv(s_if.data_z);
            exp_q.push_back({mx[OUT_W-1:0], my[OUT_W-1:0], mz[OUT_W-1:0]});
            if (mx[OUT_W] || my[OUT_W] || mz[OUT_W]) exp_sat = 1'b1;
          end
          in_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [DECIM_W-1:0] d);
    flush = 1'b1;
    decim = d;
    step();
    flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    int n;
    n = 0;
    s_if.valid  = 1'b1;
    s_if.data_x = x;
    s_if.data_y = y;
    s_if.data_z = z;
    @(negedge clk);
    while (!s_if.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(s_if.ready), 64'(1));
    step();
    s_if.valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_coord();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'h7fff_0000 + 32'($urandom_range(0, 65535));
      2:       return {($urandom_range(0, 1) != 0) ? 8'hff : 8'h00, 24'($urandom())};
      default: return 32'($urandom_range(0, 65535));
    endcase
  endfunction

  typedef struct {
    logic [31:0] x, y, z;
    logic [15:0] ex, ey, ez;
    logic        esat;
  } vec_t;

  vec_t vecs[5];
  int   dec_exp[3];
  int   rand_decims[5];
  logic acc;

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{32'h0200_0000, 32'hfe00_0000, 32'h3200_0000, 16'h0200, 16'hfe00, 16'h3200, 1'b0};
    vecs[1] = '{32'h0200_8000, 32'h0200_7fff, 32'h8000_0000, 16'h0201, 16'h0200, 16'h8000, 1'b0};
    vecs[2] = '{32'h3fff_8000, 32'hffff_8000, 32'h0000_7fff, 16'h4000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{32'h7fff_8000, 32'h7fff_ffff, 32'hffff_7fff, 16'h7fff, 16'h7fff, 16'hffff, 1'b1};
    vecs[4] = '{32'h0001_0000, 32'h0000_0000, 32'hffff_0000, 16'h0001, 16'h0000, 16'hffff, 1'b1};
    dec_exp     = '{1, 5, 9};
    rand_decims = '{1, 2, 3, 5, 0};

    s_if.valid  = 1'b0;
    s_if.data_x = '0;
    s_if.data_y = '0;
    s_if.data_z = '0;
    m_if.ready  = 1'b0;

    // Reset values and release
    repeat (3) step();
    @(negedge clk);
    check("rst_s_ready", 64'(s_if.ready), 64'(0));
    check("rst_m_valid", 64'(m_if.valid), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_data", 64'({m_if.data_x, m_if.data_y, m_if.data_z}), 64'(0));
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_edge", 64'(s_if.ready), 64'(0));
    @(negedge clk);
    check("rel_ready", 64'(s_if.ready), 64'(1));
    check("rel_m_valid", 64'(m_if.valid), 64'(0));
    check("rel_level", 64'(level), 64'(0));
    step();

    // Conversion table at decim=1
    do_flush(16'd1);
    m_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].x, vecs[i].y, vecs[i].z);
      @(negedge clk);
      check("vec_valid", 64'(m_if.valid), 64'(1));
      check("vec_x", 64'(m_if.data_x), 64'(vecs[i].ex));
      check("vec_y", 64'(m_if.data_y), 64'(vecs[i].ey));
      check("vec_z", 64'(m_if.data_z), 64'(vecs[i].ez));
      check("vec_sat", 64'(sat_flag), 64'(vecs[i].esat));
      step();
    end

    // decim=4, 12 back-to-back transfers: samples 1, 5, 9 stored
    m_if.ready = 1'b0;
    do_flush(16'd4);
    for (int k = 1; k <= 12; k++) send(32'(k) << 16, 32'h0, 32'h0);
    @(negedge clk);
    check("dec4_level", 64'(level), 64'(3));
    step();
    m_if.ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("dec4_x", 64'(m_if.data_x), 64'(dec_exp[j]));
    end
    @(negedge clk);
    check("dec4_drained", 64'(level), 64'(0));
    step();

    // Fill to full with the sink stalled, single pop, then drain in order
    m_if.ready = 1'b0;
    do_flush(16'd1);
    for (int i = 0; i < 20; i++) begin
      s_if.valid  = 1'b1;
      s_if.data_x = 32'(i) << 16;
      step();
    end
    s_if.valid = 1'b0;
    @(negedge clk);
    check("full_level", 64'(level), 64'(16));
    check("full_ready", 64'(s_if.ready), 64'(0));
    check("full_head", 64'(m_if.data_x), 64'(0));
    step();
    m_if.ready = 1'b1;
    @(negedge clk);
    check("full_ready_hold", 64'(s_if.ready), 64'(0));
    step();
    m_if.ready = 1'b0;
    @(negedge clk);
    check("pop_ready", 64'(s_if.ready), 64'(1));
    check("pop_level", 64'(level), 64'(15));
    step();
    m_if.ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("drain_x", 64'(m_if.data_x), 64'(i));
    end
    @(negedge clk);
    check("drain_level", 64'(level), 64'(0));
    step();

    // Flush at level 7 with a concurrent input beat; counter must restart
    m_if.ready = 1'b0;
    do_flush(16'd2);
    for (int k = 0; k < 13; k++) send(32'(k + 1) << 16, 32'h0, 32'h0);
    @(negedge clk);
    check("pre_flush_level", 64'(level), 64'(7));
    step();
    flush       = 1'b1;
    s_if.valid  = 1'b1;
    s_if.data_x = 32'd99 << 16;
    step();
    flush      = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
    check("flush_level", 64'(level), 64'(0));
    check("flush_m_valid", 64'(m_if.valid), 64'(0));
    step();
    send(32'd7 << 16, 32'h0, 32'h0);
    @(negedge clk);
    check("post_flush_kept", 64'(level), 64'(1));
    check("post_flush_x", 64'(m_if.data_x), 64'(7));
    step();
    m_if.ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset with level 5 and sat_flag set
    m_if.ready = 1'b0;
    do_flush(16'd1);
    send(32'h0300_0000, 32'h0, 32'h0);
    send(32'h7fff_ffff, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) send(32'h0100_0000, 32'h0, 32'h0);
    @(negedge clk);
    check("prerst_level", 64'(level), 64'(5));
    check("prerst_sat", 64'(sat_flag), 64'(1));
    step();
    reset_n = 1'b0;
    #1;
    check("arst_level", 64'(level), 64'(0));
    check("arst_m_valid", 64'(m_if.valid), 64'(0));
    check("arst_s_ready", 64'(s_if.ready), 64'(0));
    check("arst_data", 64'({m_if.data_x, m_if.data_y, m_if.data_z}), 64'(0));
    check("arst_sat", 64'(sat_flag), 64'(0));
    step();
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("arst_recover_ready", 64'(s_if.ready), 64'(1));
    step();

    // Random traffic against the model, several decimation ratios
    for (int r = 0; r < 5; r++) begin
      s_if.valid = 1'b0;
      do_flush(16'(rand_decims[r]));
      repeat (150) begin
        @(negedge clk);
        acc = s_if.valid && s_if.ready;
        step();
        if (!s_if.valid || acc) begin
          s_if.valid  = ($urandom_range(0, 3) != 0);
          s_if.data_x = rand_coord();
          s_if.data_y = rand_coord();
          s_if.data_z = rand_coord();
        end
        m_if.ready = ($urandom_range(0, 2) != 0);
      end
      s_if.valid = 1'b0;
      m_if.ready = 1'b1;
      repeat (20) step();
      @(negedge clk);
      check("rand_drained", 64'(level), 64'(0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
